hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Pipeline sequencer in the ID stage of the 5-stage MIPS core. Issues PC/IF-ID write enables,
//  ID/EX bubbles and IF/ID flushes, and schedules the shared multi-cycle mul/div unit.
//  Handles three cases: load-use hazards (1-cycle stall), mul/div occupancy (multi-cycle stall),
//  and taken-branch flushes. Works alongside the EX-stage forwarding unit.
// PARAMETERS
//  MULDIV_LAT  4   total stall cycles per mul/div issue; legal range 1..255
//  CNT_W       32  width of the stall-cycle counter (only with HAZARD_STALL_CNT_EN)
// PORTS
//  clk_i              in   1      clock; everything on rising edge
//  rst_i              in   1      synchronous, active-high reset
//  ID_instruction_RS_i in  5      rs of the instruction in ID
//  ID_instruction_RT_i in  5      rt of the instruction in ID
//  ID_muldiv_i        in   1      instruction in ID is mult/div
//  EX_mem_read_i      in   1      instruction in EX is a load
//  EX_instruction_RT_i in  5      destination rt of the load in EX
//  EX_branch_taken_i  in   1      branch resolved taken in EX
//  pc_write_o         out  1      1 = PC may update
//  IFID_write_o       out  1      1 = IF/ID register may update
//  IDEX_bubble_o      out  1      1 = load NOP into ID/EX
//  IFID_flush_o       out  1      1 = clear IF/ID to NOP
//  muldiv_start_o     out  1      1-cycle pulse: start the mul/div unit
//  muldiv_abort_o     out  1      1-cycle pulse: kill the in-flight mul/div
//  muldiv_busy_o      out  1      1 while state==MULDIV
//  stall_cycles_o     out  CNT_W  stall-cycle count (HAZARD_STALL_CNT_EN only)
// BEHAVIOUR
//  Interface: one clock clk_i; reset rst_i is synchronous and active-high.
//  Reset: state<=IDLE, cnt<=0. While rst_i=1, outputs are forced to:
//    pc_write_o=1, IFID_write_o=1, all other 1-bit outputs 0.
//  Outputs are combinational from state, cnt and inputs (0-cycle latency). State and cnt are registered.
//  Definitions:
//    lu     = EX_mem_read_i & (EX_rt!=0) & (EX_rt==ID_rs | EX_rt==ID_rt)
//    stall  => pc_write_o=0, IFID_write_o=0, IDEX_bubble_o=1
//  Output priority per cycle: branch > mul/div busy > load-use > mul/div start.
//  Branch (EX_branch_taken_i=1), any state:
//    - IFID_flush_o=1, IDEX_bubble_o=1, pc_write_o=1, IFID_write_o=1; no stall.
//    - If state==MULDIV: muldiv_abort_o=1; next state IDLE, cnt<=0.
//    - muldiv_start_o is never asserted in a branch cycle.
//  IDLE:
//    - lu=1: stall; stay IDLE. Clears naturally once the load reaches MEM.
//    - else if ID_muldiv_i: stall, muldiv_start_o=1, cnt<=MULDIV_LAT-1, next MULDIV.
//    - else: no stall.
//  MULDIV:
//    - muldiv_busy_o=1 for the whole state; ID_muldiv_i and lu are ignored.
//    - cnt!=0: stall, cnt<=cnt-1.
//    - cnt==0: release (pc_write_o=1, IFID_write_o=1, no bubble); the mul/div instruction
//      advances to EX; next IDLE.
//    - Total stall per issue = MULDIV_LAT cycles, counting the start cycle.
//      MULDIV_LAT=1 gives 1 stall cycle, then release.
//  Back-to-back mul/div: the next one is detected in the IDLE cycle after release;
//    there is no overlap.
//  Reset during MULDIV: IDLE at the next edge; no abort pulse is generated.
// CONFIGURATION
//  HAZARD_STALL_CNT_EN defined:
//    - stall_cycles_o increments each non-reset cycle where pc_write_o==0.
//    - Saturates at all-ones; cleared by rst_i.
//  HAZARD_STALL_CNT_EN undefined: the stall_cycles_o port and its counter do not exist.
// TESTING
//  1. Load-use hazard: EX load rt=5 with ID rs=5 ->
//     1 cycle with pc_write=0, IFID_write=0, IDEX_bubble=1; next cycle no stall.
//  2. Load to $0: EX load rt=0 with ID rs=0 -> no stall.
//  3. Mul/div issue, MULDIV_LAT=4: ID_muldiv=1 in IDLE ->
//     start pulse at t0; stall t0..t3; busy t1..t4; release at t4; IDLE at t5.
//  4. Branch abort: branch taken at cycle 2 of MULDIV ->
//     abort=1, flush=1, bubble=1, pc_write=1 that cycle; busy=0 next cycle.
//  5. Simultaneous events: lu=1 with ID_muldiv=1 -> load stall only, no start;
//     start fires the following cycle. Branch with ID_muldiv=1 in IDLE -> flush, no start.
//  6. Stall counter (HAZARD_STALL_CNT_EN): tests 1 then 3 -> stall_cycles_o=5;
//     with CNT_W=3, force >7 stalls -> output holds at 7.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// ID-stage hazard bus between the pipeline (master) and the stall controller (slave).
// HAZARD_STALL_CNT_EN adds the stall_cycles_o counter output and its CNT_W width.
interface hazard_stall_controller_if
`ifdef HAZARD_STALL_CNT_EN
  #(parameter int unsigned CNT_W = 32)
`endif
  ;
  logic [4:0] ID_instruction_RS_i;
  logic [4:0] ID_instruction_RT_i;
  logic       ID_muldiv_i;
  logic       EX_mem_read_i;
  logic [4:0] EX_instruction_RT_i;
  logic       EX_branch_taken_i;
  logic       pc_write_o;
  logic       IFID_write_o;
  logic       IDEX_bubble_o;
  logic       IFID_flush_o;
  logic       muldiv_start_o;
  logic       muldiv_abort_o;
  logic       muldiv_busy_o;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles_o;
`endif

  modport master (
    output ID_instruction_RS_i, ID_instruction_RT_i, ID_muldiv_i,
    output EX_mem_read_i, EX_instruction_RT_i, EX_branch_taken_i,
    input  pc_write_o, IFID_write_o, IDEX_bubble_o, IFID_flush_o,
    input  muldiv_start_o, muldiv_abort_o, muldiv_busy_o
`ifdef HAZARD_STALL_CNT_EN
    , input stall_cycles_o
`endif
  );

  modport slave (
    input  ID_instruction_RS_i, ID_instruction_RT_i, ID_muldiv_i,
    input  EX_mem_read_i, EX_instruction_RT_i, EX_branch_taken_i,
    output pc_write_o, IFID_write_o, IDEX_bubble_o, IFID_flush_o,
    output muldiv_start_o, muldiv_abort_o, muldiv_busy_o
`ifdef HAZARD_STALL_CNT_EN
    , output stall_cycles_o
`endif
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// ID-stage sequencer: load-use stalls, mul/div occupancy stalls and taken-branch flushes.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_stall_controller #(
  parameter int unsigned MULDIV_LAT = 4
`ifdef HAZARD_STALL_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input logic                     clk_i,
  input logic                     rst_i,
  hazard_stall_controller_if.slave bus
);
  localparam int unsigned LAT_W = 8;

  typedef enum logic {IDLE, MULDIV} state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               lu_c;
  logic               pc_write_c, ifid_write_c, bubble_c, flush_c;
  logic               start_c, abort_c, busy_c;

  assign lu_c = bus.EX_mem_read_i && (bus.EX_instruction_RT_i != 5'd0) &&
                ((bus.EX_instruction_RT_i == bus.ID_instruction_RS_i) ||
                 (bus.EX_instruction_RT_i == bus.ID_instruction_RT_i));

  // Next state and same-cycle outputs; priority branch > mul/div busy > load-use > start
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write_c   = 1'b1;
    ifid_write_c = 1'b1;
    bubble_c     = 1'b0;
    flush_c      = 1'b0;
    start_c      = 1'b0;
    abort_c      = 1'b0;
    busy_c       = (state_q == MULDIV);
    if (rst_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_c  = 1'b0;
    end else if (bus.EX_branch_taken_i) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      abort_c  = (state_q == MULDIV);
      state_d  = IDLE;
      cnt_d    = '0;
    end else if (state_q == MULDIV) begin
      if (cnt_q != '0) begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        bubble_c     = 1'b1;
        cnt_d        = cnt_q - LAT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end else if (lu_c) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      bubble_c     = 1'b1;
    end else if (bus.ID_muldiv_i) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      bubble_c     = 1'b1;
      start_c      = 1'b1;
      cnt_d        = LAT_W'(MULDIV_LAT - 1);
      state_d      = MULDIV;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write_o     = pc_write_c;
  assign bus.IFID_write_o   = ifid_write_c;
  assign bus.IDEX_bubble_o  = bubble_c;
  assign bus.IFID_flush_o   = flush_c;
  assign bus.muldiv_start_o = start_c;
  assign bus.muldiv_abort_o = abort_c;
  assign bus.muldiv_busy_o  = busy_c;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (!pc_write_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed and randomized check of hazard_stall_controller against a cycle-level reference model.
module tb_hazard_stall_controller;
  localparam int unsigned LAT = 4;
`ifdef HAZARD_STALL_CNT_EN
  localparam int unsigned CW      = 3;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;
`endif

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  // reference state: remaining MULDIV-state cycles (including release) and stall tally
  int   m_left = 0;
  int   m_stalls = 0;

`ifdef HAZARD_STALL_CNT_EN
  hazard_stall_controller_if #(.CNT_W(CW)) bus ();
  hazard_stall_controller #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
`else
  hazard_stall_controller_if bus ();
  hazard_stall_controller #(.MULDIV_LAT(LAT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, compare against the model, then advance both across a clock edge
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic md,
                      input logic mr, input logic [4:0] ert, input logic br);
    logic e_pc, e_ifid, e_bub, e_fl, e_st, e_ab, e_busy, lu;
    int   nxt;
    rst = r;
    bus.ID_instruction_RS_i = rs;
    bus.ID_instruction_RT_i = rt;
    bus.ID_muldiv_i         = md;
    bus.EX_mem_read_i       = mr;
    bus.EX_instruction_RT_i = ert;
    bus.EX_branch_taken_i   = br;
    #1;
    e_pc = 1'b1; e_ifid = 1'b1; e_bub = 1'b0; e_fl = 1'b0;
    e_st = 1'b0; e_ab = 1'b0; e_busy = 1'b0;
    nxt = m_left;
    lu = mr && (ert != 5'd0) && (ert == rs || ert == rt);
    if (r) begin
      nxt = 0;
    end else if (br) begin
      e_fl = 1'b1; e_bub = 1'b1;
      e_ab = (m_left > 0); e_busy = (m_left > 0);
      nxt = 0;
    end else if (m_left > 0) begin
      e_busy = 1'b1;
      if (m_left > 1) begin e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1; end
      nxt = m_left - 1;
    end else if (lu) begin
      e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1;
    end else if (md) begin
      e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1; e_st = 1'b1;
      nxt = LAT;
    end
    check("pc_write",     32'(bus.pc_write_o),     32'(e_pc));
    check("IFID_write",   32'(bus.IFID_write_o),   32'(e_ifid));
    check("IDEX_bubble",  32'(bus.IDEX_bubble_o),  32'(e_bub));
    check("IFID_flush",   32'(bus.IFID_flush_o),   32'(e_fl));
    check("muldiv_start", 32'(bus.muldiv_start_o), 32'(e_st));
    check("muldiv_abort", 32'(bus.muldiv_abort_o), 32'(e_ab));
    check("muldiv_busy",  32'(bus.muldiv_busy_o),  32'(e_busy));
`ifdef HAZARD_STALL_CNT_EN
    check("stall_cycles", 32'(bus.stall_cycles_o), 32'(m_stalls));
`endif
    @(posedge clk);
    m_left = nxt;
    if (r) m_stalls = 0;
    else if (!e_pc && m_stalls < 2**30) m_stalls = m_stalls + 1;
`ifdef HAZARD_STALL_CNT_EN
    if (m_stalls > int'(CNT_MAX)) m_stalls = int'(CNT_MAX);
`endif
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.ID_instruction_RS_i = '0;
    bus.ID_instruction_RT_i = '0;
    bus.ID_muldiv_i         = 1'b0;
    bus.EX_mem_read_i       = 1'b0;
    bus.EX_instruction_RT_i = '0;
    bus.EX_branch_taken_i   = 1'b0;

    // reset: pc/IFID write enabled, everything else low
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0);

    // load-use on rs, then the load has moved on
    step(1'b0, 5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b0);
    idle_step();
    // load into $0 never stalls
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);

    // mul/div issue: start + 4 MULDIV cycles, then idle
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < int'(LAT); i++) step(1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
    idle_step();
`ifdef HAZARD_STALL_CNT_EN
    check("stall_cnt_after_lu_and_muldiv", 32'(bus.stall_cycles_o), 32'd5);
`endif

    // branch abort on the second MULDIV cycle
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    idle_step();
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
    idle_step();

    // load-use wins over mul/div start; start follows next cycle
    step(1'b0, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0);
    step(1'b0, 5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b0);
    for (int i = 0; i < int'(LAT); i++) idle_step();
    // branch in IDLE with a mul/div in ID: flush, no start
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1);
    idle_step();

    // back-to-back mul/div held in ID
    for (int i = 0; i < 2 * int'(LAT) + 3; i++) step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    idle_step();
`ifdef HAZARD_STALL_CNT_EN
    check("stall_cnt_saturated", 32'(bus.stall_cycles_o), 32'(CNT_MAX));
`endif

    // reset during MULDIV: no abort, idle afterwards
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    idle_step();
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    idle_step();
    idle_step();

    // randomized traffic with narrow register numbers to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 63) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
